// File: rtl/axil_dma_engine_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axil_dma_engine_if
// Brief    : AXI4-Lite bus bundle between the DMA master and the interconnect.
// Revision : 1.0 - initial release
// ============================================================================
interface axil_dma_engine_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int c_BYTES = DATA_W / 8;

    logic                ARVALID;
    logic                ARREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic                RVALID;
    logic                RREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                AWVALID;
    logic                AWREADY;
    logic [ADDR_W-1:0]   AWADDR;
    logic                WVALID;
    logic                WREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [c_BYTES-1:0]  WSTRB;
    logic                BVALID;
    logic                BREADY;
    logic [1:0]          BRESP;

    modport master (
        output ARVALID, ARADDR, RREADY, AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
        input  ARREADY, RVALID, RDATA, RRESP, AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  ARVALID, ARADDR, RREADY, AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
        output ARREADY, RVALID, RDATA, RRESP, AWREADY, WREADY, BVALID, BRESP
    );
endinterface
`default_nettype wire

// File: rtl/axil_dma_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axil_dma_engine
// Brief    : AXI4-Lite master DMA; pipelined reads into a FIFO, one write in flight.
// Revision : 1.0 - initial release
// ============================================================================
module axil_dma_engine #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              trigger,
    input  wire logic [LEN_W-1:0]  length,
    input  wire logic [ADDR_W-1:0] source_address,
    input  wire logic [ADDR_W-1:0] destination_address,
    axil_dma_engine_if.master      axil,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);
    localparam int c_BYTES = DATA_W / 8;
    localparam int c_SHIFT = $clog2(c_BYTES);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    wstate_t             r_wstate;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0]  r_fifo_count, r_reads_out;
    logic [LEN_W-1:0]    r_words, r_reads_issued, r_writes_done;
    logic [c_BYTES-1:0]  r_last_strb, r_wstrb;
    logic [ADDR_W-1:0]   r_araddr, r_awaddr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_arvalid, r_awvalid, r_wvalid, r_bready;
    logic                r_busy, r_done, r_error, r_err_pending;

    logic                w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
    logic [c_CNT_W:0]    w_credit_used;
    logic                w_ar_allowed, w_wr_start, w_err_finish, w_ok_finish;
    logic [LEN_W:0]      w_len_round;
    logic [LEN_W-1:0]    w_words;
    logic [c_SHIFT-1:0]  w_rem;
    logic [c_BYTES-1:0]  w_last_strb;
    logic [ADDR_W-1:0]   w_src_aligned, w_dst_aligned;

    assign w_ar_hs = r_arvalid & axil.ARREADY;
    assign w_r_hs  = r_busy & axil.RVALID;
    assign w_aw_hs = r_awvalid & axil.AWREADY;
    assign w_w_hs  = r_wvalid & axil.WREADY;
    assign w_b_hs  = r_bready & axil.BVALID;

    // Buffered plus in-flight reads never exceed the FIFO, so RREADY can stay high.
    assign w_credit_used = (c_CNT_W+1)'(r_fifo_count) + (c_CNT_W+1)'(r_reads_out);
    assign w_ar_allowed  = r_busy & ~r_err_pending & ~r_arvalid
                         & (r_reads_issued < r_words)
                         & (w_credit_used < (c_CNT_W+1)'(FIFO_DEPTH));
    assign w_wr_start    = r_busy & (r_wstate == W_IDLE) & ~r_err_pending
                         & (r_fifo_count != '0) & (r_writes_done < r_words);
    assign w_err_finish  = r_busy & r_err_pending & (r_reads_out == '0)
                         & ~r_arvalid & (r_wstate == W_IDLE);
    assign w_ok_finish   = r_busy & ~r_err_pending & (r_wstate == W_IDLE)
                         & (r_writes_done == r_words);

    assign w_len_round   = {1'b0, length} + (LEN_W+1)'(c_BYTES - 1);
    assign w_words       = LEN_W'(w_len_round >> c_SHIFT);
    assign w_rem         = length[c_SHIFT-1:0];
    assign w_src_aligned = source_address & ~ADDR_W'(c_BYTES - 1);
    assign w_dst_aligned = destination_address & ~ADDR_W'(c_BYTES - 1);

    always_comb begin
        w_last_strb = '0;
        for (int i = 0; i < c_BYTES; i++) begin
            w_last_strb[i] = (w_rem == '0) || (i < int'(w_rem));
        end
    end

    always_ff @(posedge clk) begin
        if (w_r_hs) begin
            r_mem[r_wr_ptr] <= axil.RDATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate       <= W_IDLE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_fifo_count   <= '0;
            r_reads_out    <= '0;
            r_words        <= '0;
            r_reads_issued <= '0;
            r_writes_done  <= '0;
            r_last_strb    <= '0;
            r_wstrb        <= '0;
            r_araddr       <= '0;
            r_awaddr       <= '0;
            r_wdata        <= '0;
            r_arvalid      <= 1'b0;
            r_awvalid      <= 1'b0;
            r_wvalid       <= 1'b0;
            r_bready       <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_err_pending  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (trigger) begin
                    r_busy         <= 1'b1;
                    r_error        <= 1'b0;
                    r_err_pending  <= 1'b0;
                    r_araddr       <= w_src_aligned;
                    r_awaddr       <= w_dst_aligned;
                    r_words        <= w_words;
                    r_last_strb    <= w_last_strb;
                    r_reads_issued <= '0;
                    r_writes_done  <= '0;
                end
            end else if (w_err_finish || w_ok_finish) begin
                // Leftover words from an aborted job are discarded here.
                r_busy        <= 1'b0;
                r_done        <= 1'b1;
                r_error       <= r_err_pending;
                r_err_pending <= 1'b0;
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_fifo_count  <= '0;
                r_reads_out   <= '0;
            end else begin
                if (w_ar_allowed) begin
                    r_arvalid <= 1'b1;
                end
                if (w_ar_hs) begin
                    r_arvalid      <= 1'b0;
                    r_araddr       <= r_araddr + ADDR_W'(c_BYTES);
                    r_reads_issued <= r_reads_issued + LEN_W'(1);
                end
                r_reads_out <= r_reads_out + c_CNT_W'(w_ar_hs) - c_CNT_W'(w_r_hs);

                if (w_r_hs) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                    if (axil.RRESP != 2'b00) begin
                        r_err_pending <= 1'b1;
                    end
                end
                if (w_w_hs) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                r_fifo_count <= r_fifo_count + c_CNT_W'(w_r_hs) - c_CNT_W'(w_w_hs);

                case (r_wstate)
                    W_IDLE: begin
                        if (w_wr_start) begin
                            r_wstate  <= W_REQ;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_wdata   <= r_mem[r_rd_ptr];
                            r_wstrb   <= (r_writes_done + LEN_W'(1) == r_words) ? r_last_strb : '1;
                        end
                    end
                    W_REQ: begin
                        if (w_aw_hs) begin
                            r_awvalid <= 1'b0;
                        end
                        if (w_w_hs) begin
                            r_wvalid <= 1'b0;
                        end
                        if ((!r_awvalid || axil.AWREADY) && (!r_wvalid || axil.WREADY)) begin
                            r_wstate <= W_RESP;
                            r_bready <= 1'b1;
                        end
                    end
                    W_RESP: begin
                        if (w_b_hs) begin
                            r_bready      <= 1'b0;
                            r_writes_done <= r_writes_done + LEN_W'(1);
                            r_awaddr      <= r_awaddr + ADDR_W'(c_BYTES);
                            r_wstate      <= W_IDLE;
                            if (axil.BRESP != 2'b00) begin
                                r_err_pending <= 1'b1;
                            end
                        end
                    end
                    default: r_wstate <= W_IDLE;
                endcase
            end
        end
    end

    assign axil.ARVALID = r_arvalid;
    assign axil.ARADDR  = r_araddr;
    assign axil.RREADY  = r_busy;
    assign axil.AWVALID = r_awvalid;
    assign axil.AWADDR  = r_awaddr;
    assign axil.WVALID  = r_wvalid;
    assign axil.WDATA   = r_wdata;
    assign axil.WSTRB   = r_wstrb;
    assign axil.BREADY  = r_bready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
endmodule
`default_nettype wire

// File: tb/tb_axil_dma_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axil_dma_engine
// Brief    : Directed vector bench with a zero/variable-wait AXI4-Lite slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_dma_engine;
    localparam int DATA_W = 32, ADDR_W = 32, LEN_W = 16, FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst, trigger, busy, done, error;
    logic [LEN_W-1:0]  length;
    logic [ADDR_W-1:0] src, dst;
    always #5 clk = ~clk;

    axil_dma_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axil ();

    axil_dma_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .length(length),
        .source_address(src), .destination_address(dst), .axil(axil),
        .busy(busy), .done(done), .error(error)
    );

    function automatic logic [31:0] src_word(input logic [31:0] a);
        return {a[31:16] + 16'h1234, a[15:0] ^ 16'hC3A5};
    endfunction

    int ar_delay = 0, aw_delay = 0, w_delay = 0, rd_err_idx = -1, wr_err_idx = -1;
    int ar_wait, aw_wait, w_wait, ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    int stab_viol, err_viol, max_occ, done_cnt, valid_cnt;
    logic s_rvalid, s_bvalid, err_flag, err_flag_d;
    logic [1:0]  s_rresp, s_bresp;
    logic [31:0] s_rdata;
    logic [31:0] ar_log[$], aw_log[$], wd_log[$];
    logic [3:0]  ws_log[$];
    logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;

    assign axil.ARREADY = (ar_wait >= ar_delay);
    assign axil.AWREADY = (aw_wait >= aw_delay);
    assign axil.WREADY  = (w_wait >= w_delay);
    assign axil.RVALID  = s_rvalid;
    assign axil.RDATA   = s_rdata;
    assign axil.RRESP   = s_rresp;
    assign axil.BVALID  = s_bvalid;
    assign axil.BRESP   = s_bresp;

    always @(posedge clk) begin
        if (rst) begin
            s_rvalid <= 0; s_bvalid <= 0; s_rresp <= 0; s_bresp <= 0; s_rdata <= 0;
            ar_wait <= 0; aw_wait <= 0; w_wait <= 0;
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            stab_viol <= 0; err_viol <= 0; max_occ <= 0; done_cnt <= 0; valid_cnt <= 0;
            err_flag <= 0; err_flag_d <= 0;
            p_arv <= 0; p_arr <= 0; p_awv <= 0; p_awr <= 0; p_wv <= 0; p_wr <= 0;
            ar_log.delete(); aw_log.delete(); wd_log.delete(); ws_log.delete();
        end else begin
            if (axil.ARVALID && axil.ARREADY) begin
                ar_wait <= 0; ar_cnt <= ar_cnt + 1; ar_log.push_back(axil.ARADDR);
                s_rvalid <= 1; s_rdata <= src_word(axil.ARADDR);
                s_rresp <= (ar_cnt == rd_err_idx) ? 2'd2 : 2'd0;
            end else begin
                if (axil.ARVALID) ar_wait <= ar_wait + 1;
                if (s_rvalid && axil.RREADY) s_rvalid <= 0;
            end
            if (s_rvalid && axil.RREADY) begin
                r_cnt <= r_cnt + 1;
                if (s_rresp != 0) err_flag <= 1;
            end
            if (axil.AWVALID && axil.AWREADY) begin
                aw_wait <= 0; aw_cnt <= aw_cnt + 1; aw_log.push_back(axil.AWADDR);
            end else if (axil.AWVALID) aw_wait <= aw_wait + 1;
            if (axil.WVALID && axil.WREADY) begin
                w_wait <= 0; w_cnt <= w_cnt + 1; wd_log.push_back(axil.WDATA); ws_log.push_back(axil.WSTRB);
            end else if (axil.WVALID) w_wait <= w_wait + 1;
            if (s_bvalid && axil.BREADY) begin
                s_bvalid <= 0; b_cnt <= b_cnt + 1;
                if (s_bresp != 0) err_flag <= 1;
            end else if (!s_bvalid && aw_cnt > b_cnt && w_cnt > b_cnt) begin
                s_bvalid <= 1; s_bresp <= (b_cnt == wr_err_idx) ? 2'd3 : 2'd0;
            end
            err_flag_d <= err_flag;
            // A valid held without ready must keep its payload.
            if ((p_arv && !p_arr && (!axil.ARVALID || axil.ARADDR != p_araddr)) ||
                (p_awv && !p_awr && (!axil.AWVALID || axil.AWADDR != p_awaddr)) ||
                (p_wv && !p_wr && (!axil.WVALID || axil.WDATA != p_wdata || axil.WSTRB != p_wstrb)))
                stab_viol <= stab_viol + 1;
            if ((!p_arv && axil.ARVALID && err_flag_d) || (!p_awv && axil.AWVALID && err_flag_d))
                err_viol <= err_viol + 1;
            p_arv <= axil.ARVALID; p_arr <= axil.ARREADY; p_araddr <= axil.ARADDR;
            p_awv <= axil.AWVALID; p_awr <= axil.AWREADY; p_awaddr <= axil.AWADDR;
            p_wv <= axil.WVALID; p_wr <= axil.WREADY; p_wdata <= axil.WDATA; p_wstrb <= axil.WSTRB;
            if (ar_cnt - w_cnt > max_occ) max_occ <= ar_cnt - w_cnt;
            if (done) done_cnt <= done_cnt + 1;
            if (axil.ARVALID || axil.AWVALID || axil.WVALID) valid_cnt <= valid_cnt + 1;
        end
    end

    typedef struct {
        logic [15:0] len;
        logic [31:0] src, dst, src_base, dst_base;
        int          ar_d, aw_d, w_d, rd_err, wr_err;
        int          exp_words;
        logic [3:0]  exp_strb;
        logic        exp_err;
        logic        chk_fill;
    } vec_t;
    vec_t vecs[11];

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1; repeat (2) @(negedge clk); rst = 0;
    endtask

    task automatic start_job(input logic [15:0] l, input logic [31:0] s, input logic [31:0] d);
        @(negedge clk); trigger = 1; length = l; src = s; dst = d;
        @(negedge clk); trigger = 0;
    endtask

    task automatic wait_done(output bit seen, output logic b, output logic e);
        seen = 0; b = 1'bx; e = 1'bx;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (done) begin seen = 1; b = busy; e = error; end
        end
    endtask

    task automatic run_vec(input int v, input bit with_reset);
        bit seen; logic b, e; vec_t t;
        t = vecs[v];
        ar_delay = t.ar_d; aw_delay = t.aw_d; w_delay = t.w_d;
        rd_err_idx = t.rd_err; wr_err_idx = t.wr_err;
        if (with_reset) do_reset();
        start_job(t.len, t.src, t.dst);
        wait_done(seen, b, e);
        check($sformatf("v%0d_done_seen", v), 64'(seen), 1);
        check($sformatf("v%0d_busy_at_done", v), 64'(b), 0);
        check($sformatf("v%0d_error", v), 64'(e), 64'(t.exp_err));
        repeat (4) @(negedge clk);
        check($sformatf("v%0d_done_pulses", v), 64'(done_cnt), 1);
        check($sformatf("v%0d_stability", v), 64'(stab_viol), 0);
        check($sformatf("v%0d_req_after_err", v), 64'(err_viol), 0);
        check($sformatf("v%0d_reads_drained", v), 64'(r_cnt), 64'(ar_cnt));
        check($sformatf("v%0d_occupancy_le", v), 64'(max_occ <= FIFO_DEPTH), 1);
        if (t.chk_fill) check($sformatf("v%0d_fifo_filled", v), 64'(max_occ), FIFO_DEPTH);
        if (t.exp_err) begin
            check($sformatf("v%0d_writes_le", v), 64'(aw_cnt <= t.exp_words), 1);
        end else begin
            check($sformatf("v%0d_ar_count", v), 64'(ar_cnt), 64'(t.exp_words));
            check($sformatf("v%0d_aw_count", v), 64'(aw_cnt), 64'(t.exp_words));
            check($sformatf("v%0d_w_count", v), 64'(w_cnt), 64'(t.exp_words));
            check($sformatf("v%0d_b_count", v), 64'(b_cnt), 64'(t.exp_words));
            for (int i = 0; i < t.exp_words; i++) begin
                logic [31:0] sa, da;
                sa = t.src_base + 32'(4 * i);
                da = t.dst_base + 32'(4 * i);
                check($sformatf("v%0d_araddr%0d", v, i), 64'(ar_log[i]), 64'(sa));
                check($sformatf("v%0d_awaddr%0d", v, i), 64'(aw_log[i]), 64'(da));
                check($sformatf("v%0d_wdata%0d", v, i), 64'(wd_log[i]), 64'(src_word(sa)));
                check($sformatf("v%0d_wstrb%0d", v, i), 64'(ws_log[i]),
                      64'((i == t.exp_words - 1) ? t.exp_strb : 4'hF));
            end
        end
    endtask

    initial begin
        bit seen; logic b, e;
        //          len    src           dst           src_base      dst_base      ar aw  w  rerr werr words strb err fill
        vecs[0]  = '{16'd16, 32'h1000,     32'h2000,     32'h1000,     32'h2000,     0, 0,  0, -1, -1, 4,  4'hF, 0, 0};
        vecs[1]  = '{16'd7,  32'h1000,     32'h2000,     32'h1000,     32'h2000,     0, 0,  0, -1, -1, 2,  4'h7, 0, 0};
        vecs[2]  = '{16'd0,  32'h1000,     32'h2000,     32'h1000,     32'h2000,     0, 0,  0, -1, -1, 0,  4'hF, 0, 0};
        vecs[3]  = '{16'd64, 32'h1000,     32'h2000,     32'h1000,     32'h2000,     0, 50, 0, -1, -1, 16, 4'hF, 0, 1};
        vecs[4]  = '{16'd16, 32'h1000,     32'h2000,     32'h1000,     32'h2000,     0, 1,  2, -1, -1, 4,  4'hF, 0, 0};
        vecs[5]  = '{16'd16, 32'h1000,     32'h2000,     32'h1000,     32'h2000,     0, 2,  1, -1, -1, 4,  4'hF, 0, 0};
        vecs[6]  = '{16'd16, 32'h1000,     32'h2000,     32'h1000,     32'h2000,     0, 1,  1, -1, -1, 4,  4'hF, 0, 0};
        vecs[7]  = '{16'd13, 32'h1003,     32'h2006,     32'h1000,     32'h2004,     2, 0,  0, -1, -1, 4,  4'h1, 0, 0};
        vecs[8]  = '{16'd16, 32'h1000,     32'h2000,     32'h1000,     32'h2000,     0, 0,  0, 1,  -1, 1,  4'hF, 1, 0};
        vecs[9]  = '{16'd16, 32'h1000,     32'h2000,     32'h1000,     32'h2000,     0, 0,  0, -1, 0,  1,  4'hF, 1, 0};
        vecs[10] = '{16'd16, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFFC, 0, 0,  0, -1, -1, 4,  4'hF, 0, 0};

        rst = 1; trigger = 0; length = 0; src = 0; dst = 0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({axil.ARVALID, axil.AWVALID, axil.WVALID, axil.RREADY, axil.BREADY, busy, done, error}), 0);
        check("rst_addr", 64'({axil.ARADDR, axil.AWADDR}), 0);
        check("rst_wdata", 64'({axil.WDATA, axil.WSTRB}), 0);
        rst = 0;

        for (int v = 0; v < 11; v++) run_vec(v, 1'b1);

        // Zero length: one busy cycle, then done, and the bus stays idle.
        ar_delay = 0; aw_delay = 0; w_delay = 0; rd_err_idx = -1; wr_err_idx = -1;
        do_reset();
        @(negedge clk); trigger = 1; length = 0; src = 32'h1000; dst = 32'h2000;
        @(negedge clk); trigger = 0;
        check("len0_busy_c1", 64'({busy, done}), 64'(2'b10));
        @(negedge clk);
        check("len0_done_c2", 64'({busy, done, error}), 64'(3'b010));
        @(negedge clk);
        check("len0_done_c3", 64'(done), 0);
        check("len0_no_valids", 64'(valid_cnt), 0);

        // A trigger while busy must not start a second job.
        aw_delay = 10;
        do_reset();
        start_job(16'd16, 32'h1000, 32'h2000);
        repeat (5) @(negedge clk);
        trigger = 1; length = 16'd4; src = 32'h8000; dst = 32'h9000;
        @(negedge clk); trigger = 0;
        wait_done(seen, b, e);
        check("busytrig_done", 64'(seen), 1);
        check("busytrig_aw_count", 64'(aw_cnt), 4);
        check("busytrig_awaddr0", 64'(aw_log[0]), 64'h2000);
        check("busytrig_wdata3", 64'(wd_log[3]), 64'(src_word(32'h100C)));
        repeat (10) @(negedge clk);
        check("busytrig_one_done", 64'(done_cnt), 1);
        check("busytrig_idle", 64'(busy), 0);

        // Reset in the middle of a job aborts it without a done pulse.
        aw_delay = 5;
        do_reset();
        start_job(16'd64, 32'h1000, 32'h2000);
        repeat (20) @(negedge clk);
        check("midrst_busy_before", 64'(busy), 1);
        rst = 1;
        @(posedge clk); #1;
        check("midrst_ctrl", 64'({axil.ARVALID, axil.AWVALID, axil.WVALID, axil.RREADY, axil.BREADY, busy, done, error}), 0);
        check("midrst_addr", 64'({axil.ARADDR, axil.AWADDR}), 0);
        check("midrst_wdata", 64'({axil.WDATA, axil.WSTRB}), 0);
        @(negedge clk); rst = 0;
        repeat (20) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt), 0);
        check("midrst_idle", 64'(busy), 0);
        run_vec(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
